// File: rtl/riscv_rvalid_stall_if.sv
// OBI request/response signals between core, memory and the rvalid stall shim.
// The slave modport is the shim's view; the master modport is the core/memory side.
interface riscv_rvalid_stall_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_core_i;
  logic                  gnt_core_i;
  logic                  rvalid_mem_i;
  logic [DATA_WIDTH-1:0] rdata_mem_i;
  logic                  rvalid_core_o;
  logic [DATA_WIDTH-1:0] rdata_core_o;
  logic                  block_gnt_o;

  modport slave (
    input  req_core_i,
    input  gnt_core_i,
    input  rvalid_mem_i,
    input  rdata_mem_i,
    output rvalid_core_o,
    output rdata_core_o,
    output block_gnt_o
  );

  modport master (
    output req_core_i,
    output gnt_core_i,
    output rvalid_mem_i,
    output rdata_mem_i,
    input  rvalid_core_o,
    input  rdata_core_o,
    input  block_gnt_o
  );
endinterface

// File: rtl/riscv_rvalid_stall.sv
// Delays memory responses to the core by a fixed or pseudo-random count, in order.
// Optional macro RVALID_STALL_IDLE_SCRAMBLE_EN drives the LFSR value on idle rdata.
module riscv_rvalid_stall #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  riscv_rvalid_stall_if.slave       bus,
  input  logic                      en_stall_i,
  input  logic [31:0]               stall_mode_i,
  input  logic [31:0]               max_stall_i,
  input  logic [31:0]               valid_stall_i,
  output logic                      overflow_o
);

  localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [31:0] {
    ModeNone     = 32'd0,
    ModeStandard = 32'd1,
    ModeRandom   = 32'd2
  } stallMode_e;

  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [31:0]           delay_q [FIFO_DEPTH];
  logic [PtrW-1:0]       rdPtr_q, wrPtr_q;
  logic [CntW-1:0]       count_q, outstanding_q;
  logic [31:0]           lfsr_q, lfsr_d;
  logic                  overflow_q;

  logic                  fifoEmpty, fifoFull, pop, accept, drop, useLfsr, reqGranted;
  logic [31:0]           newDelay;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifoEmpty  = (count_q == '0);
  assign fifoFull   = (count_q == CntW'(FIFO_DEPTH));
  assign pop        = !fifoEmpty && (delay_q[rdPtr_q] == 32'd0);
  assign accept     = bus.rvalid_mem_i && (!fifoFull || pop);
  assign drop       = bus.rvalid_mem_i && fifoFull && !pop;
  assign useLfsr    = bus.rvalid_mem_i && en_stall_i && (stall_mode_i == ModeRandom);
  assign reqGranted = bus.req_core_i && bus.gnt_core_i;

  // Galois form of x^32+x^22+x^2+x+1, shifting right.
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    newDelay = 32'd0;
    if (en_stall_i) begin
      if (stall_mode_i == ModeStandard) begin
        newDelay = valid_stall_i;
      end else if (stall_mode_i == ModeRandom) begin
        // All-ones bound would overflow max+1, so the raw value is already in range.
        newDelay = (max_stall_i == 32'hFFFF_FFFF) ? lfsr_q
                                                  : lfsr_q % (max_stall_i + 32'd1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
      lfsr_q        <= 32'h1;
    end else begin
      if (useLfsr) lfsr_q <= lfsr_d;

      // Only the head entry counts down; later entries keep their full delay.
      if (pop) begin
        rdPtr_q <= nextPtr(rdPtr_q);
      end else if (!fifoEmpty) begin
        delay_q[rdPtr_q] <= delay_q[rdPtr_q] - 32'd1;
      end

      if (accept) begin
        data_q[wrPtr_q]  <= bus.rdata_mem_i;
        delay_q[wrPtr_q] <= newDelay;
        wrPtr_q          <= nextPtr(wrPtr_q);
      end

      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;

      if (drop) overflow_q <= 1'b1;

      if (reqGranted && !pop && (outstanding_q < CntW'(FIFO_DEPTH))) begin
        outstanding_q <= outstanding_q + 1'b1;
      end else if (pop && !reqGranted && (outstanding_q != '0)) begin
        outstanding_q <= outstanding_q - 1'b1;
      end
    end
  end

  assign bus.rvalid_core_o = pop;
  assign bus.block_gnt_o   = (outstanding_q >= CntW'(FIFO_DEPTH));
  assign overflow_o        = overflow_q;

`ifdef RVALID_STALL_IDLE_SCRAMBLE_EN
  assign bus.rdata_core_o = pop ? data_q[rdPtr_q] : DATA_WIDTH'(lfsr_q);
`else
  assign bus.rdata_core_o = pop ? data_q[rdPtr_q] : '0;
`endif

endmodule
